// File: rtl/sopu_pkg.sv
// Shared constants and FSM state type for the line buffer bank.
//   IMG_WIDTH_DEF / IMG_HEIGHT_DEF : default image geometry
//   KERNEL_SIZE                    : window edge length (7x7 patch)
//   NUM_LINES                      : stored rows behind the newest row
//   state_t                        : line buffer sequencing states
package sopu_pkg;
   localparam int IMG_WIDTH_DEF  = 28;
   localparam int IMG_HEIGHT_DEF = 28;
   localparam int KERNEL_SIZE    = 7;
   localparam int NUM_LINES      = KERNEL_SIZE - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/line_ram.sv
// One image row of pixel storage with a single read-before-write port.
//   clk   : clock
//   we    : write enable; writes wdata at addr on the rising edge
//   addr  : column address
//   wdata : pixel to store
//   rdata : current (pre-write) contents at addr, combinational
// Storage has no reset; the consumer masks rows that were never written.
module line_ram #(
   parameter int DEPTH = 28
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata
);
   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
   end

   assign rdata = r_mem[addr];
endmodule

// File: rtl/line_buffer_bank.sv
// Six-row line buffer feeding a 7x7 sliding window from a raster pixel stream.
//   clk, rst                     : clock, asynchronous active-high reset
//   frame_start                  : begin a frame (honoured in IDLE/DONE only)
//   pixel_in, pixel_valid        : raster-order pixel input
//   pixel_ready                  : pixel accepted when pixel_valid & pixel_ready
//   line_0_out..line_5_out       : column pixels from rows r-6..r-1
//   pixel_out                    : registered copy of the accepted pixel
//   shift_enable                 : one-cycle pulse per accepted pixel
//   window_valid                 : shift_enable with a complete 7x7 patch
//   frame_done                   : pulse with the final shift of a frame
//
// state  | meaning
// IDLE   | waiting for frame_start after reset
// FILL   | accepting rows 0..5, window not yet complete
// STREAM | accepting rows 6..IMG_HEIGHT-1
// DONE   | frame finished, waiting for the next frame_start
module line_buffer_bank
   import sopu_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic [7:0] pixel_in,
   input  logic       pixel_valid,
   output logic       pixel_ready,
   output logic [7:0] line_0_out,
   output logic [7:0] line_1_out,
   output logic [7:0] line_2_out,
   output logic [7:0] line_3_out,
   output logic [7:0] line_4_out,
   output logic [7:0] line_5_out,
   output logic [7:0] pixel_out,
   output logic       shift_enable,
   output logic       window_valid,
   output logic       frame_done
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] WIN_COL  = COL_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0] WIN_ROW  = ROW_W'(KERNEL_SIZE - 1);

   state_t           r_state;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;
   logic             r_pixel_ready;
   logic             r_shift_enable;
   logic             r_window_valid;
   logic             r_frame_done;
   logic [7:0]       r_pixel_out;
   logic [7:0]       r_line_out [NUM_LINES];

   logic             w_accept;
   logic [7:0]       w_rdata [NUM_LINES];
   logic [7:0]       w_wdata [NUM_LINES];

   assign w_accept = pixel_valid & r_pixel_ready;

   // Each accept moves column c of every stored row one line older.
   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      if (g == NUM_LINES - 1) begin : g_newest
         assign w_wdata[g] = pixel_in;
      end else begin : g_older
         assign w_wdata[g] = w_rdata[g+1];
      end

      line_ram #(.DEPTH(IMG_WIDTH)) u_ram (
         .clk   (clk),
         .we    (w_accept),
         .addr  (r_col),
         .wdata (w_wdata[g]),
         .rdata (w_rdata[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_row          <= '0;
         r_col          <= '0;
         r_pixel_ready  <= 1'b0;
         r_shift_enable <= 1'b0;
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
         r_pixel_out    <= '0;
         for (int k = 0; k < NUM_LINES; k++) r_line_out[k] <= '0;
      end else begin
         r_shift_enable <= 1'b0;
         r_window_valid <= 1'b0;
         r_frame_done   <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (frame_start) begin
                  r_state       <= FILL;
                  r_row         <= '0;
                  r_col         <= '0;
                  r_pixel_ready <= 1'b1;
               end
            end
            FILL, STREAM: begin
               if (w_accept) begin
                  r_pixel_out    <= pixel_in;
                  r_shift_enable <= 1'b1;
                  r_window_valid <= (r_row >= WIN_ROW) && (r_col >= WIN_COL);
                  // Line k holds row r-6+k, which does not exist while r < 6-k.
                  for (int k = 0; k < NUM_LINES; k++) begin
                     r_line_out[k] <= (r_row < ROW_W'(NUM_LINES - k)) ? '0 : w_rdata[k];
                  end
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     if (r_row == LAST_ROW) begin
                        r_row         <= '0;
                        r_state       <= DONE;
                        r_pixel_ready <= 1'b0;
                        r_frame_done  <= 1'b1;
                     end else begin
                        r_row <= r_row + 1'b1;
                        if (r_row == ROW_W'(NUM_LINES - 1)) r_state <= STREAM;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pixel_ready  = r_pixel_ready;
   assign shift_enable = r_shift_enable;
   assign window_valid = r_window_valid;
   assign frame_done   = r_frame_done;
   assign pixel_out    = r_pixel_out;
   assign line_0_out   = r_line_out[0];
   assign line_1_out   = r_line_out[1];
   assign line_2_out   = r_line_out[2];
   assign line_3_out   = r_line_out[3];
   assign line_4_out   = r_line_out[4];
   assign line_5_out   = r_line_out[5];
endmodule

// File: tb/tb_line_buffer_bank.sv
module tb_line_buffer_bank;
   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NPIX = W * H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [7:0] pixel_in = 8'd0;
   logic       pixel_valid = 1'b0;
   logic       pixel_ready;
   logic [7:0] line_0_out, line_1_out, line_2_out, line_3_out, line_4_out, line_5_out;
   logic [7:0] pixel_out;
   logic       shift_enable, window_valid, frame_done;
   logic [7:0] lines [6];

   int checks = 0;
   int errors = 0;

   assign lines[0] = line_0_out;
   assign lines[1] = line_1_out;
   assign lines[2] = line_2_out;
   assign lines[3] = line_3_out;
   assign lines[4] = line_4_out;
   assign lines[5] = line_5_out;

   line_buffer_bank #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .pixel_ready  (pixel_ready),
      .line_0_out   (line_0_out),
      .line_1_out   (line_1_out),
      .line_2_out   (line_2_out),
      .line_3_out   (line_3_out),
      .line_4_out   (line_4_out),
      .line_5_out   (line_5_out),
      .pixel_out    (pixel_out),
      .shift_enable (shift_enable),
      .window_valid (window_valid),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: the frame is a 2-D image of accepted pixels; for the pixel at
   // (r,c) the window column holds image rows r-6..r-1 at column c, zero above row 0.
   task automatic drive_frame(input string tag, input bit rand_valid, input bit rand_data,
                              input bit inject_fs, input int lim);
      logic [7:0] img [H][W];
      logic [7:0] exp_line [6];
      logic [7:0] exp_pix;
      logic [7:0] exp54 [6];
      logic [7:0] d;
      bit         v, have_exp, exp_shift, exp_wv, exp_done;
      int         n, cyc, done_cnt, r, c, fs_n;
      exp54 = '{8'd6, 8'd14, 8'd22, 8'd30, 8'd38, 8'd46};
      n = 0; cyc = 0; done_cnt = 0; have_exp = 0; fs_n = -1; exp_pix = 0;
      for (int k = 0; k < 6; k++) exp_line[k] = 0;

      @(negedge clk);
      frame_start = 1'b1;
      pixel_valid = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;

      while (n < lim && cyc < 400) begin
         v = rand_valid ? bit'($urandom_range(0, 1)) : 1'b1;
         d = rand_data ? 8'($urandom) : 8'(n);
         pixel_valid = v;
         pixel_in    = d;
         if (inject_fs && (n == 10 || n == 50) && fs_n != n) begin
            frame_start = 1'b1;
            fs_n = n;
         end
         checks++;
         if (pixel_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready n=%0d got %b want 1", tag, n, pixel_ready);
         end
         @(negedge clk);
         frame_start = 1'b0;
         if (v) begin
            r = n / W;
            c = n % W;
            img[r][c] = d;
            for (int k = 0; k < 6; k++)
               exp_line[k] = (r >= 6 - k) ? img[r-6+k][c] : 8'd0;
            exp_pix = d;
            exp_shift = 1; exp_wv = (r >= 6 && c >= 6); exp_done = (n == NPIX - 1);
            have_exp = 1;
            n++;
         end else begin
            exp_shift = 0; exp_wv = 0; exp_done = 0;
         end
         checks++;
         if (shift_enable !== exp_shift) begin
            errors++;
            $display("FAIL %s shift_enable n=%0d got %b want %b", tag, n, shift_enable, exp_shift);
         end
         checks++;
         if (window_valid !== exp_wv) begin
            errors++;
            $display("FAIL %s window_valid n=%0d got %b want %b", tag, n, window_valid, exp_wv);
         end
         checks++;
         if (frame_done !== exp_done) begin
            errors++;
            $display("FAIL %s frame_done n=%0d got %b want %b", tag, n, frame_done, exp_done);
         end
         if (frame_done === 1'b1) done_cnt++;
         if (have_exp) begin
            checks++;
            if (pixel_out !== exp_pix) begin
               errors++;
               $display("FAIL %s pixel_out n=%0d got %0d want %0d", tag, n, pixel_out, exp_pix);
            end
            for (int k = 0; k < 6; k++) begin
               checks++;
               if (lines[k] !== exp_line[k]) begin
                  errors++;
                  $display("FAIL %s line_%0d n=%0d got %0d want %0d", tag, k, n, lines[k], exp_line[k]);
               end
            end
         end
         // Fixed landmarks of the row*8+col pattern.
         if (v && !rand_data && n == 55) begin
            for (int k = 0; k < 6; k++) begin
               checks++;
               if (lines[k] !== exp54[k]) begin
                  errors++;
                  $display("FAIL %s px54 line_%0d got %0d want %0d", tag, k, lines[k], exp54[k]);
               end
            end
            checks++;
            if (pixel_out !== 8'd54 || window_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s px54 pix/wv got %0d/%b want 54/1", tag, pixel_out, window_valid);
            end
         end
         if (v && !rand_data && n == 20) begin
            checks++;
            if ({line_5_out, line_4_out, line_3_out, line_2_out, line_1_out, line_0_out, 7'(window_valid)}
                !== {8'd11, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 7'd0}) begin
               errors++;
               $display("FAIL %s px19 l5=%0d l4=%0d l3=%0d l0=%0d wv=%b want 11 3 0 0 0",
                        tag, line_5_out, line_4_out, line_3_out, line_0_out, window_valid);
            end
         end
         cyc++;
      end
      pixel_valid = 1'b0;

      checks++;
      if (n !== lim) begin
         errors++;
         $display("FAIL %s timeout accepted %0d want %0d", tag, n, lim);
      end
      if (lim == NPIX) begin
         checks++;
         if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s frame_done_count got %0d want 1", tag, done_cnt);
         end
         for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({pixel_ready, shift_enable, frame_done} !== 3'b000) begin
               errors++;
               $display("FAIL %s after_done ready/shift/done got %b%b%b want 000",
                        tag, pixel_ready, shift_enable, frame_done);
            end
         end
         pixel_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({pixel_ready, shift_enable, window_valid, frame_done, pixel_out} !== 12'd0) begin
         errors++;
         $display("FAIL reset ctrl got %b%b%b%b pix %0d want 0", pixel_ready, shift_enable,
                  window_valid, frame_done, pixel_out);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (lines[k] !== 8'd0) begin
            errors++;
            $display("FAIL reset line_%0d got %0d want 0", k, lines[k]);
         end
      end
      rst = 1'b0;
      pixel_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({pixel_ready, shift_enable} !== 2'b00) begin
         errors++;
         $display("FAIL idle_no_start ready/shift got %b%b want 00", pixel_ready, shift_enable);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_reset_mid_frame;
      drive_frame("partial", 1'b0, 1'b0, 1'b0, 20);
      rst = 1'b1;
      #1;
      checks++;
      if ({pixel_ready, shift_enable, pixel_out, line_4_out, line_5_out} !== 26'd0) begin
         errors++;
         $display("FAIL midrst async ready=%b shift=%b pix=%0d l4=%0d l5=%0d want 0",
                  pixel_ready, shift_enable, pixel_out, line_4_out, line_5_out);
      end
      @(negedge clk);
      rst = 1'b0;
      pixel_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({pixel_ready, shift_enable} !== 2'b00) begin
         errors++;
         $display("FAIL midrst needs_start ready/shift got %b%b want 00", pixel_ready, shift_enable);
      end
      pixel_valid = 1'b0;
      drive_frame("full_after_rst", 1'b0, 1'b0, 1'b0, NPIX);
   endtask

   task automatic test_random_valid;
      drive_frame("gappy_pattern", 1'b1, 1'b0, 1'b0, NPIX);
   endtask

   task automatic test_frame_start_ignored;
      drive_frame("fs_ignored", 1'b0, 1'b1, 1'b1, NPIX);
   endtask

   task automatic test_back_to_back;
      drive_frame("b2b_first", 1'b1, 1'b1, 1'b0, NPIX);
      drive_frame("b2b_second", 1'b1, 1'b1, 1'b0, NPIX);
   endtask

   initial begin
      test_reset;
      test_reset_mid_frame;
      test_random_valid;
      test_frame_start_ignored;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/line_buffer_bank.md
LINE_BUFFER_BANK -- requirements
Module: line_buffer_bank

Interface
REQ-001 The module SHALL have parameter IMG_WIDTH, default 28, pixels per image row (minimum 7).
REQ-002 The module SHALL have parameter IMG_HEIGHT, default 28, rows per frame (minimum 7).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port frame_start, input, 1, one-cycle request to begin a frame.
REQ-006 The module SHALL have port pixel_in, input, 8, raster-order pixel from UART receive path.
REQ-007 The module SHALL have port pixel_valid, input, 1, pixel_in valid.
REQ-008 The module SHALL have port pixel_ready, output, 1, module accepts pixel_in this cycle.
REQ-009 The module SHALL have ports line_0_out..line_5_out, output, 8 each, column pixels from rows r-6..r-1 feeding the window's sr_line inputs.
REQ-010 The module SHALL have port pixel_out, output, 8, registered copy of the accepted pixel feeding the window's newest row.
REQ-011 The module SHALL have port shift_enable, output, 1, one-cycle pulse: window shifts in line_*_out and pixel_out.
REQ-012 The module SHALL have port window_valid, output, 1, qualifies shift_enable: the window now holds a complete 7x7 patch.
REQ-013 The module SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame.

Function
REQ-014 The FSM SHALL have states IDLE, FILL, STREAM, DONE.
REQ-015 IDLE/DONE -> FILL on frame_start; row and col counters clear to 0 on that transition.
REQ-016 frame_start SHALL be ignored in FILL and STREAM.
REQ-017 pixel_ready SHALL be 1 exactly in FILL and STREAM; accept = pixel_valid & pixel_ready.
REQ-018 On accept at column c: line_k storage[c] <= line_(k+1) storage[c] for k=0..4; line_5 storage[c] <= pixel_in.
REQ-019 The same edge SHALL register line_k_out <= old line_k storage[c] and pixel_out <= pixel_in.
REQ-020 shift_enable SHALL assert the cycle after each accept, aligned with line_*_out and pixel_out; latency 1.
REQ-021 line_k_out SHALL be forced to 0 when the accepted pixel's row < 6-k, so unwritten storage never escapes.
REQ-022 window_valid SHALL equal shift_enable AND (accepted row >= 6) AND (accepted col >= 6).
REQ-023 col SHALL increment per accept and wrap from IMG_WIDTH-1 to 0, incrementing row.
REQ-024 FILL -> STREAM when row reaches 6.
REQ-025 Accept at row IMG_HEIGHT-1, col IMG_WIDTH-1 SHALL go to DONE and pulse frame_done on the next cycle, coincident with the final shift_enable.
REQ-026 Outputs SHALL hold their values between accepts; shift_enable/window_valid are 0 without an accept.
REQ-027 Counter widths SHALL be $clog2 of IMG_WIDTH and IMG_HEIGHT.

Reset
REQ-028 rst SHALL force IDLE, counters 0, all outputs 0 (pixel_ready 0) asynchronously.
REQ-029 Line storage SHALL NOT be reset; REQ-021 masking guarantees determinism.
REQ-030 rst mid-frame SHALL abandon the frame; a new frame_start is required.

Structure
REQ-031 The package sopu_pkg SHALL hold IMG_WIDTH/IMG_HEIGHT defaults, KERNEL_SIZE=7, NUM_LINES=6 and the FSM state enum.
REQ-032 One sub-module line_ram (IMG_WIDTH x 8, one read-before-write port) SHALL be instantiated six times.

Verification (IMG_WIDTH=IMG_HEIGHT=8, pixel = row*8+col)
REQ-033 Reset mid-frame, then frame_start, stream 64 pixels -> frame_done pulse exactly once, after pixel 63; pixel_ready 0 afterwards.
REQ-034 Accept row 6 col 6 (54) -> next cycle shift_enable=1, window_valid=1, pixel_out=54, line_0..5 = 6,14,22,30,38,46.
REQ-035 Accept row 2 col 3 (19) -> line_5_out=11, line_4_out=3, line_0..3_out=0, window_valid=0.
REQ-036 pixel_valid toggled randomly 50% -> output sequence identical to continuous stream; no shift_enable without accept.
REQ-037 frame_start pulsed during STREAM -> ignored, counters and outputs unaffected.
REQ-038 Two back-to-back frames (frame_start in DONE) -> second frame row-0 outputs masked to 0 despite stale storage.
